// File: rtl/expmu_scheduler.sv
// expmu_scheduler: round-robin arbiter that shares one S0*exp(t*mu) curve
// engine between NREQ requesters. Latches the winner's operands, pulses the
// engine start, forwards streamed samples into a banked curve RAM and returns
// a per-requester ack with an error flag (bad sample count or timeout).
//
// Optional feature: define EXPMU_SCHED_TIMEOUT_EN to enable a RUN-cycle
// watchdog. On expiry the run is acked with oErr=1 and the scheduler enters
// FLUSH so the still-running engine is drained before the next grant.
module expmu_scheduler #(
    parameter int NREQ      = 4,
    parameter int LOG_NREQ  = 2,
    parameter int LOGT      = 9,
    parameter int T_MAX     = 511,
    parameter int FLUSH_CYC = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          iReq,
    input  logic [NREQ*18-1:0]       iMu,
    input  logic [NREQ*18-1:0]       iS,
    output logic [NREQ-1:0]          oGrant,
    output logic [NREQ-1:0]          oAck,
    output logic                     oErr,
    output logic                     oBusy,
    output logic                     oEngStart,
    output logic [17:0]              oEngMu,
    output logic [17:0]              oEngS,
    input  logic [17:0]              iEngData,
    input  logic [LOGT-1:0]          iEngAddr,
    input  logic                     iEngValid,
    input  logic                     iEngDone,
    output logic                     oWrEn,
    output logic [LOG_NREQ+LOGT-1:0] oWrAddr,
    output logic [17:0]              oWrData
);

    localparam int CNT_W   = LOGT + 1;
    localparam int QUIET_W = $clog2(FLUSH_CYC + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(T_MAX + 1);
    localparam logic [QUIET_W-1:0] FLUSH_END = QUIET_W'(FLUSH_CYC);
    localparam logic [NREQ-1:0]    ONE_HOT0  = NREQ'(1);
    localparam logic [LOG_NREQ-1:0] LAST_RST = LOG_NREQ'(NREQ - 1);

`ifdef EXPMU_SCHED_TIMEOUT_EN
    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_END = RUN_W'(TIMEOUT);
`endif

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t                     state_r;
    logic [QUIET_W-1:0]         quiet_r;
    logic [LOG_NREQ-1:0]        last_r;
    logic [LOG_NREQ-1:0]        win_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [NREQ-1:0]            grant_r;
    logic [NREQ-1:0]            ack_r;
    logic                       err_r;
    logic                       busy_r;
    logic                       start_r;
    logic [17:0]                mu_r;
    logic [17:0]                s_r;
    logic                       wr_en_r;
    logic [LOG_NREQ+LOGT-1:0]   wr_addr_r;
    logic [17:0]                wr_data_r;
`ifdef EXPMU_SCHED_TIMEOUT_EN
    logic [RUN_W-1:0]           run_cnt_r;
`endif

    logic                       pick_found_s;
    logic [LOG_NREQ-1:0]        pick_idx_s;
    logic [17:0]                mu_sel_s;
    logic [17:0]                s_sel_s;
    logic [CNT_W-1:0]           cnt_nxt_s;

    // Round-robin pick: search from (last + 1) mod NREQ, first set bit wins.
    function automatic logic [LOG_NREQ:0] rr_pick(input logic [NREQ-1:0] req,
                                                  input logic [LOG_NREQ-1:0] last);
        logic                found;
        logic [LOG_NREQ-1:0] pick;
        logic [LOG_NREQ-1:0] idx;
        int                  pos;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(last) + 1 + k) % NREQ;
            idx = LOG_NREQ'(pos);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    // Arbitration result, operand slice mux and saturating sample count.
    always_comb begin
        {pick_found_s, pick_idx_s} = rr_pick(iReq, last_r);
        mu_sel_s = iMu[18*int'(pick_idx_s) +: 18];
        s_sel_s  = iS[18*int'(pick_idx_s) +: 18];
        if (iEngValid && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_FLUSH;
            quiet_r   <= '0;
            last_r    <= LAST_RST;
            win_r     <= '0;
            cnt_r     <= '0;
            grant_r   <= '0;
            ack_r     <= '0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            start_r   <= 1'b0;
            mu_r      <= 18'd0;
            s_r       <= 18'd0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 18'd0;
`ifdef EXPMU_SCHED_TIMEOUT_EN
            run_cnt_r <= '0;
`endif
        end else begin
            // pulse outputs default low each cycle
            start_r <= 1'b0;
            ack_r   <= '0;
            err_r   <= 1'b0;
            wr_en_r <= 1'b0;
            case (state_r)
                ST_FLUSH: begin
                    grant_r <= '0;
                    if (iEngDone) begin
                        quiet_r <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (iEngValid) begin
                        quiet_r <= '0;
                        busy_r  <= 1'b1;
                    end else if ((quiet_r + QUIET_W'(1)) == FLUSH_END) begin
                        quiet_r <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        quiet_r <= quiet_r + QUIET_W'(1);
                        busy_r  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (pick_found_s) begin
                        win_r   <= pick_idx_s;
                        mu_r    <= mu_sel_s;
                        s_r     <= s_sel_s;
                        start_r <= 1'b1;
                        grant_r <= ONE_HOT0 << pick_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_START;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    cnt_r   <= '0;
`ifdef EXPMU_SCHED_TIMEOUT_EN
                    run_cnt_r <= '0;
`endif
                    busy_r  <= 1'b1;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    busy_r <= 1'b1;
                    cnt_r  <= cnt_nxt_s;
                    if (iEngValid) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= {win_r, iEngAddr};
                        wr_data_r <= iEngData;
                    end else begin
                        wr_en_r   <= 1'b0;
                    end
                    if (iEngDone) begin
                        ack_r   <= ONE_HOT0 << win_r;
                        err_r   <= (cnt_nxt_s != FULL_CNT);
                        state_r <= ST_FIN;
`ifdef EXPMU_SCHED_TIMEOUT_EN
                    end else if ((run_cnt_r + RUN_W'(1)) == RUN_END) begin
                        // engine is presumed hung: ack with error, then drain it
                        ack_r   <= ONE_HOT0 << win_r;
                        err_r   <= 1'b1;
                        last_r  <= win_r;
                        quiet_r <= '0;
                        state_r <= ST_FLUSH;
                    end else begin
                        run_cnt_r <= run_cnt_r + RUN_W'(1);
`else
                    end else begin
                        state_r <= ST_RUN;
`endif
                    end
                end
                ST_FIN: begin
                    last_r  <= win_r;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    grant_r <= '0;
                    quiet_r <= '0;
                    busy_r  <= 1'b1;
                    state_r <= ST_FLUSH;
                end
            endcase
        end
    end

    assign oGrant    = grant_r;
    assign oAck      = ack_r;
    assign oErr      = err_r;
    assign oBusy     = busy_r;
    assign oEngStart = start_r;
    assign oEngMu    = mu_r;
    assign oEngS     = s_r;
    assign oWrEn     = wr_en_r;
    assign oWrAddr   = wr_addr_r;
    assign oWrData   = wr_data_r;

endmodule
